mips_mem_port_arbiter: RTL and testbench
========================================

// Module: mips_mem_port_arbiter
// PURPOSE
//  Shares the single-port unified Mem array of the MIPS32 core between three requesters:
//  instruction fetch (IF), data access (MEM stage load/store) and an external
//  loader/debug port (program load, register-file dumps via memory).
//  Fixed priority with IF anti-starvation; one access in flight; fixed-latency memory.
//  Sits between the pipeline stage logic and the memory macro, in the clk1 domain.
// PARAMETERS
//  AW       10  word-address width
//  DW       32  data width
//  LAT      2   memory read latency in cycles (>=1); mem_rdata valid LAT cycles after mem_en
//  MAX_WAIT 3   consecutive IF denials before IF is promoted above the data port
// PORTS
//  clk1       in   1   single clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   IF read request; held until if_ack
//  if_addr    in   AW  IF word address
//  if_ack     out  1   IF access complete (1-cycle pulse); rdata valid this cycle
//  dm_req     in   1   data request; held until dm_ack
//  dm_we      in   1   1=store, 0=load
//  dm_addr    in   AW  data word address
//  dm_wdata   in   DW  store data
//  dm_ack     out  1   data access complete (1-cycle pulse)
//  ext_req    in   1   loader/debug request; held until ext_ack
//  ext_we     in   1   1=write, 0=read
//  ext_addr   in   AW  loader word address
//  ext_wdata  in   DW  loader write data
//  ext_ack    out  1   loader access complete (1-cycle pulse)
//  rdata      out  DW  read data, shared; valid only in an ack cycle
//  busy       out  1   access in flight
//  mem_en     out  1   memory strobe, 1-cycle pulse per access
//  mem_we     out  1   memory write enable, valid with mem_en
//  mem_addr   out  AW  memory address, held from issue until ack
//  mem_wdata  out  DW  memory write data, valid with mem_en
//  mem_rdata  in   DW  memory read data, valid LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state IDLE; if_ack/dm_ack/ext_ack/busy/mem_en/mem_we=0; mem_addr/mem_wdata/rdata=0;
//    latency counter and IF wait counter = 0.
//  - FSM IDLE -> ACCESS -> IDLE.
//    IDLE: if any req, select winner, latch we/addr/wdata (IF: we=0), pulse mem_en this cycle (T),
//    busy=1, load cnt=LAT-1, go ACCESS. No req: stay IDLE, all strobes 0.
//    ACCESS: decrement cnt each cycle; at cycle T+LAT assert winner's ack for exactly 1 cycle,
//    rdata=mem_rdata (writes: rdata=0), busy drops, return to IDLE.
//  - No arbitration in ACCESS cycles; next issue earliest T+LAT+1 -> 1 access per LAT+1 cycles.
//  - Requesters drop req the cycle after ack; a req still high in IDLE is a new request.
//  - Priority: ext > dm > if. Promotion: if if_wait == MAX_WAIT, IF beats dm (never ext).
//  - if_wait: +1 at each IDLE decision where if_req=1 and IF loses; cleared on IF grant
//    or when if_req=0; saturates at MAX_WAIT.
//  - Requests changing while in ACCESS are ignored until next IDLE; latched cmd is not altered.
//  - rst mid-access: abandon in-flight access, no ack issued, IDLE next cycle; an already
//    strobed write may still land in memory.
//  - At most one ack high per cycle; mem_en never high in two consecutive cycles.
//  - Addresses pass through unchecked; wrap is the memory's concern.
// TESTING (LAT=2, MAX_WAIT=3)
//  1. Mem[5]=32'h2801000a; if_req, if_addr=5 at T -> mem_en@T, if_ack@T+2, rdata=32'h2801000a.
//  2. if_req and dm_req (load addr 3) both rise at T -> dm_ack@T+2; IF issued T+3, if_ack@T+5.
//  3. ext write 32'hfc000000 to addr 8 with dm_req also high -> ext_ack@T+2; dm next;
//     IF load of addr 8 then returns 32'hfc000000.
//  4. dm_req always re-raised, if_req held -> dm wins 3 decisions, IF granted 4th; if_wait=0 after.
//  5. rst at T+1 of an IF read -> no if_ack at T+2; busy=0, mem_en=0, IDLE from T+2.
//  6. 10 back-to-back IF reads -> acks exactly 3 cycles apart; no overlap of mem_en pulses.

Source files
------------

// File: rtl/mips_mem_port_arbiter.sv
// Shares the unified single-port Mem array between IF, data and loader ports.
// Fixed priority ext > dm > if, with IF promotion after MAX_WAIT denials.
module mips_mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic [1:0] { S_IF, S_DM, S_EXT } src_t;

  state_t        state;
  src_t          src;
  logic [CW-1:0] cnt;
  logic [WW-1:0] if_wait;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          g_ext, g_dm, g_if;
  logic          promote, issue, done;
  src_t          sel_src;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign promote = (if_wait == WW'(MAX_WAIT));
  assign g_ext   = ext_req;
  assign g_if    = !ext_req && if_req && (!dm_req || promote);
  assign g_dm    = !ext_req && dm_req && !g_if;
  assign issue   = !rst && (state == IDLE) && (if_req || dm_req || ext_req);
  assign done    = !rst && (state == ACCESS) && (cnt == '0);

  always_comb begin
    sel_src   = S_IF;
    sel_we    = 1'b0;
    sel_addr  = if_addr;
    sel_wdata = '0;
    unique case (1'b1)
      g_ext: begin
        sel_src   = S_EXT;
        sel_we    = ext_we;
        sel_addr  = ext_addr;
        sel_wdata = ext_wdata;
      end
      g_dm: begin
        sel_src   = S_DM;
        sel_we    = dm_we;
        sel_addr  = dm_addr;
        sel_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  // The strobe leaves in the decision cycle; the address is then held
  // from the latched command until the ack.
  assign mem_en    = issue;
  assign mem_we    = issue && sel_we;
  assign mem_addr  = issue ? sel_addr : cmd_addr;
  assign mem_wdata = issue ? sel_wdata : cmd_wdata;
  assign busy      = issue || (state == ACCESS);

  assign if_ack  = done && (src == S_IF);
  assign dm_ack  = done && (src == S_DM);
  assign ext_ack = done && (src == S_EXT);
  assign rdata   = (done && !cmd_we) ? mem_rdata : '0;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      src       <= S_IF;
      cnt       <= '0;
      if_wait   <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      if (!if_req || (issue && g_if))
        if_wait <= '0;
      else if (issue && !promote)
        if_wait <= if_wait + 1'b1;
      unique case (state)
        IDLE: begin
          if (issue) begin
            state     <= ACCESS;
            src       <= sel_src;
            cnt       <= CW'(LAT - 1);
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Directed bench for mips_mem_port_arbiter with a 2-cycle memory model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mips_mem_port_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, ext_req, ext_we;
  logic [9:0]  if_addr, dm_addr, ext_addr;
  logic [31:0] dm_wdata, ext_wdata;
  logic        if_ack, dm_ack, ext_ack, busy;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rdata;

  logic [31:0] tb_mem [0:1023];
  logic [31:0] rd_s1;

  int checks = 0;
  int passed = 0;

  always #5 clk1 = ~clk1;

  mips_mem_port_arbiter dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk1) begin
    if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    rd_s1     <= tb_mem[mem_addr];
    mem_rdata <= rd_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk1);
    #1;
  endtask

  task automatic smp();
    @(negedge clk1);
  endtask

  int n;
  logic last_en;

  initial begin
    for (int k = 0; k < 1024; k++) tb_mem[k] = 32'ha500_0000 | k;
    tb_mem[5] = 32'h2801000a;
    rst = 1'b1;
    if_req = 0; dm_req = 0; ext_req = 0;
    dm_we = 0; ext_we = 0;
    if_addr = '0; dm_addr = '0; ext_addr = '0;
    dm_wdata = '0; ext_wdata = '0;
    nxt(); nxt();
    rst = 1'b0;
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acks", {if_ack, dm_ack, ext_ack}, 0);

    // 1: single IF read
    nxt(); if_req = 1; if_addr = 5;
    smp();
    chk("t1_en", mem_en, 1);
    chk("t1_addr", mem_addr, 5);
    chk("t1_busy", busy, 1);
    nxt(); smp();
    chk("t1_noack", if_ack, 0);
    chk("t1_en2", mem_en, 0);
    chk("t1_hold", mem_addr, 5);
    nxt(); smp();
    chk("t1_ack", if_ack, 1);
    chk("t1_rdata", rdata, 32'h2801000a);
    nxt(); if_req = 0;
    smp();
    chk("t1_idle", busy, 0);
    chk("t1_ackdrop", if_ack, 0);

    // 2: dm beats IF on simultaneous requests
    nxt();
    if_req = 1; if_addr = 7;
    dm_req = 1; dm_we = 0; dm_addr = 3;
    smp();
    chk("t2_dm_addr", mem_addr, 3);
    nxt(); smp();
    nxt(); smp();
    chk("t2_dm_ack", dm_ack, 1);
    chk("t2_if_noack", if_ack, 0);
    chk("t2_dm_rdata", rdata, 32'ha500_0003);
    nxt(); dm_req = 0;
    smp();
    chk("t2_if_en", mem_en, 1);
    chk("t2_if_addr", mem_addr, 7);
    nxt(); smp();
    nxt(); smp();
    chk("t2_if_ack", if_ack, 1);
    chk("t2_if_rdata", rdata, 32'ha500_0007);
    nxt(); if_req = 0;
    smp();

    // 3: ext write wins over dm store, then IF reads it back
    nxt();
    ext_req = 1; ext_we = 1; ext_addr = 8; ext_wdata = 32'hfc000000;
    dm_req = 1; dm_we = 1; dm_addr = 9; dm_wdata = 32'h0000_0055;
    smp();
    chk("t3_ext_we", mem_we, 1);
    chk("t3_ext_addr", mem_addr, 8);
    chk("t3_ext_wdata", mem_wdata, 32'hfc000000);
    nxt(); smp();
    nxt(); smp();
    chk("t3_ext_ack", ext_ack, 1);
    chk("t3_dm_noack", dm_ack, 0);
    chk("t3_wr_rdata", rdata, 0);
    nxt(); ext_req = 0;
    smp();
    chk("t3_dm_en", mem_en, 1);
    chk("t3_dm_addr", mem_addr, 9);
    nxt(); smp();
    nxt(); smp();
    chk("t3_dm_ack", dm_ack, 1);
    nxt(); dm_req = 0; dm_we = 0; if_req = 1; if_addr = 8;
    smp();
    chk("t3_if_en", mem_en, 1);
    nxt(); smp();
    nxt(); smp();
    chk("t3_if_ack", if_ack, 1);
    chk("t3_if_rdata", rdata, 32'hfc000000);
    chk("t3_mem9", tb_mem[9], 32'h0000_0055);
    nxt(); if_req = 0;
    smp();

    // 4: IF promotion after three dm wins
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (k == 0) begin
        if_req = 1; if_addr = 2;
        dm_req = 1; dm_we = 0; dm_addr = 4;
      end
      smp();
      chk("t4_grant", mem_addr, (k < 3) ? 32'd4 : 32'd2);
      nxt(); smp();
      nxt(); smp();
      chk("t4_dm_ack", dm_ack, (k < 3) ? 32'd1 : 32'd0);
      chk("t4_if_ack", if_ack, (k < 3) ? 32'd0 : 32'd1);
      chk("t4_wait", dut.if_wait, (k < 3) ? k + 1 : 0);
    end
    nxt(); if_req = 0; dm_req = 0;
    smp();

    // 5: reset during an IF read
    nxt(); if_req = 1; if_addr = 5;
    smp();
    chk("t5_en", mem_en, 1);
    nxt(); rst = 1; if_req = 0;
    smp();
    nxt(); rst = 0;
    smp();
    chk("t5_noack", if_ack, 0);
    chk("t5_busy", busy, 0);
    chk("t5_en", mem_en, 0);
    nxt(); smp();
    chk("t5_noack2", if_ack, 0);

    // 6: ten back-to-back IF reads
    nxt(); if_req = 1; if_addr = 10;
    smp();
    last_en = mem_en;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      do begin
        nxt();
        if (n == 0 && i > 0) if_addr = 10'(10 + i);
        smp();
        n++;
        chk("t6_en_pair", {31'd0, mem_en & last_en}, 0);
        last_en = mem_en;
      end while (!if_ack && n < 8);
      chk("t6_gap", n, (i == 0) ? 32'd2 : 32'd3);
      chk("t6_rdata", rdata, 32'ha500_0000 | (10 + i));
    end
    nxt(); if_req = 0;
    smp();
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
